// File: rtl/vector_output_capture_if.sv
// Capture-side bus for vector_output_capture: CPU strobe/vector in, lane stream out, FIFO status.
// The timestamp signal exists only when VECTOR_OUTPUT_CAPTURE_TIMESTAMP_EN is defined.
interface vector_output_capture_if #(
  parameter int DATA_WIDTH  = 19,
  parameter int VECTOR_SIZE = 6,
  parameter int DEPTH       = 8,
  parameter int TS_WIDTH    = 16
);
  logic                              outFlag;
  logic [VECTOR_SIZE*DATA_WIDTH-1:0] out;
  logic [DATA_WIDTH-1:0]             laneData;
  logic [$clog2(VECTOR_SIZE)-1:0]    laneIndex;
  logic                              laneLast;
  logic                              laneValid;
  logic                              laneReady;
  logic [$clog2(DEPTH):0]            level;
  logic                              full;
  logic                              empty;
  logic [15:0]                       dropCount;
`ifdef VECTOR_OUTPUT_CAPTURE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0]               timestamp;
`endif

  modport master (
    output outFlag, out, laneReady,
    input  laneData, laneIndex, laneLast, laneValid, level, full, empty, dropCount
`ifdef VECTOR_OUTPUT_CAPTURE_TIMESTAMP_EN
    , input timestamp
`endif
  );

  modport slave (
    input  outFlag, out, laneReady,
    output laneData, laneIndex, laneLast, laneValid, level, full, empty, dropCount
`ifdef VECTOR_OUTPUT_CAPTURE_TIMESTAMP_EN
    , output timestamp
`endif
  );
endinterface

// File: rtl/vector_output_capture.sv
// Buffers whole CPU vectors on outFlag and streams them lane by lane over valid/ready; strobe->laneValid 2 cycles,
// lanes hold while laneReady=0, pushes to a full FIFO are dropped and counted. Option: VECTOR_OUTPUT_CAPTURE_TIMESTAMP_EN.
module vector_output_capture #(
  parameter int DATA_WIDTH  = 19,
  parameter int VECTOR_SIZE = 6,
  parameter int DEPTH       = 8,
  parameter int TS_WIDTH    = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  vector_output_capture_if.slave bus
);
  localparam int VW = DATA_WIDTH * VECTOR_SIZE;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(VECTOR_SIZE);
  localparam logic [LW-1:0] LAST_IDX = LW'(VECTOR_SIZE - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  logic [VW-1:0]         mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           level, level_nxt;
  logic [15:0]           drop_count;
  state_t                state;
  logic                  lane_valid, lane_last;
  logic [LW-1:0]         lane_index;
  logic [DATA_WIDTH-1:0] lane_sel;
  logic [VW-1:0]         head;
  logic                  full, empty, push, pop;

  assign full      = (level == FULL_LVL);
  assign empty     = (level == '0);
  assign push      = bus.outFlag & ~full;
  assign pop       = lane_valid & bus.laneReady & (lane_index == LAST_IDX);
  assign level_nxt = level + (AW + 1)'(push) - (AW + 1)'(pop);
  assign head      = mem[rd_ptr];

  always_comb begin
    lane_sel = '0;
    for (int i = 0; i < VECTOR_SIZE; i++)
      if (lane_index == LW'(i)) lane_sel = head[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Head slot cannot be written while it is being streamed: it is only freed by pop.
  always_ff @(posedge clock)
    if (!reset && push) mem[wr_ptr] <= bus.out;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      drop_count <= '0;
      state      <= IDLE;
      lane_valid <= 1'b0;
      lane_index <= '0;
      lane_last  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (bus.outFlag && full && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      level <= level_nxt;
      case (state)
        IDLE: begin
          if (!empty) begin
            state      <= SEND;
            lane_valid <= 1'b1;
            lane_index <= '0;
            lane_last  <= 1'b0;
          end
        end
        SEND: begin
          if (bus.laneReady) begin
            if (lane_index != LAST_IDX) begin
              lane_index <= lane_index + 1'b1;
              lane_last  <= (lane_index + 1'b1 == LAST_IDX);
            end else begin
              lane_index <= '0;
              lane_last  <= 1'b0;
              // Back-to-back vectors continue without a bubble.
              if (level_nxt == '0) begin
                state      <= IDLE;
                lane_valid <= 1'b0;
              end
            end
          end
        end
        default: begin
          state      <= IDLE;
          lane_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef VECTOR_OUTPUT_CAPTURE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [TS_WIDTH-1:0] ts_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 1'b1;
  end

  always_ff @(posedge clock)
    if (!reset && push) ts_mem[wr_ptr] <= ts_cnt;

  assign bus.timestamp = lane_valid ? ts_mem[rd_ptr] : '0;
`endif

  assign bus.laneData  = lane_valid ? lane_sel : '0;
  assign bus.laneIndex = lane_index;
  assign bus.laneLast  = lane_last;
  assign bus.laneValid = lane_valid;
  assign bus.level     = level;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.dropCount = drop_count;
endmodule
